// File: rtl/n_counter_pkg.sv
// Shared definitions for the n-channel up/down counter bank and its summing FSM.
//   sum_state_e : states of the sequential summing FSM
//   MODE_WRAP / MODE_SAT : counter limit behaviour selectors
//   sum_width() : width needed to hold the sum of all channels without overflow
package n_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } sum_state_e;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  function automatic int sum_width(input int width, input int channels);
    return width + $clog2(channels);
  endfunction

endpackage

// File: rtl/updown_counter_chan.sv
// One channel of the counter bank: loadable up/down counter with limit detect.
//   clk, reset      : clock, synchronous active-high reset
//   clear           : active-low synchronous clear of the count
//   en, load        : count enable, load strobe (load has priority)
//   up_down         : 1 counts up, 0 counts down
//   load_val        : value taken on load
//   cnt             : registered count
//   ovf             : one-cycle pulse after the counter wrapped or clamped
module updown_counter_chan
  import n_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (!clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up_down) begin
        if (cnt_q == '1) begin
          ovf_d = 1'b1;
          if (SATURATE == MODE_SAT) cnt_d = '1;
          else                      cnt_d = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          ovf_d = 1'b1;
          if (SATURATE == MODE_SAT) cnt_d = '0;
          else                      cnt_d = '1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/n_channel_updown_counter_sum.sv
// Bank of CHANNELS up/down counters plus a sequential summing engine.
//   clk, reset          : clock, synchronous active-high reset (clears everything)
//   clear               : active-low synchronous clear of the counters only
//   en/load/up_down     : per-channel controls, bit i drives channel i
//   load_val, cnt       : channel i at [i*WIDTH +: WIDTH]
//   ovf                 : per-channel one-cycle wrap/clamp pulse
//   sum_req             : start a sum, sampled only when idle
//   sum_busy            : high during ACC and DONE
//   sum_valid, sum      : one-cycle completion pulse, held total of snapshotted counts
module n_channel_updown_counter_sum
  import n_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SATURATE = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    clear,
  input  logic [CHANNELS-1:0]                     en,
  input  logic [CHANNELS-1:0]                     load,
  input  logic [CHANNELS-1:0]                     up_down,
  input  logic [CHANNELS*WIDTH-1:0]               load_val,
  output logic [CHANNELS*WIDTH-1:0]               cnt,
  output logic [CHANNELS-1:0]                     ovf,
  input  logic                                    sum_req,
  output logic                                    sum_busy,
  output logic                                    sum_valid,
  output logic [sum_width(WIDTH, CHANNELS)-1:0]   sum
);

  localparam int SW = sum_width(WIDTH, CHANNELS);
  localparam int IW = $clog2(CHANNELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    updown_counter_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE != 0)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .en       (en[g]),
      .load     (load[g]),
      .up_down  (up_down[g]),
      .load_val (load_val[g*WIDTH +: WIDTH]),
      .cnt      (cnt[g*WIDTH +: WIDTH]),
      .ovf      (ovf[g])
    );
  end

  sum_state_e                       state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   snap_q, snap_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [SW-1:0]                    acc_q, acc_d;
  logic [SW-1:0]                    sum_q, sum_d;
  logic                             valid_q, valid_d;
  logic [SW-1:0]                    acc_next;

  // The snapshot decouples the sum from live counter activity, so clear,
  // load and counting during ACC cannot change the result.
  assign acc_next = acc_q + SW'(snap_q[idx_q]);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sum_req) begin
          snap_d  = cnt;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_next;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_next;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum_busy  = (state_q != IDLE);
  assign sum_valid = valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_n_channel_updown_counter_sum.sv
// Directed bench: one wrapping and one saturating instance share all inputs.
module tb_n_channel_updown_counter_sum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b1;
  logic [7:0]  en = '0;
  logic [7:0]  load = '0;
  logic [7:0]  up_down = '0;
  logic [63:0] load_val = '0;
  logic        sum_req = 1'b0;

  logic [63:0] w_cnt, s_cnt;
  logic [7:0]  w_ovf, s_ovf;
  logic        w_busy, s_busy, w_valid, s_valid;
  logic [10:0] w_sum, s_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  n_channel_updown_counter_sum #(.WIDTH(8), .CHANNELS(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .load(load), .up_down(up_down),
    .load_val(load_val), .cnt(w_cnt), .ovf(w_ovf), .sum_req(sum_req),
    .sum_busy(w_busy), .sum_valid(w_valid), .sum(w_sum)
  );

  n_channel_updown_counter_sum #(.WIDTH(8), .CHANNELS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .load(load), .up_down(up_down),
    .load_val(load_val), .cnt(s_cnt), .ovf(s_ovf), .sum_req(sum_req),
    .sum_busy(s_busy), .sum_valid(s_valid), .sum(s_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) load_val[i*8 +: 8] = 8'(i + 1);
    load = '1;
    tick();
    load = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = '1; up_down = '1;
    repeat (3) tick();
    n_checks++; if (w_cnt !== 64'h0 || s_cnt !== 64'h0) begin n_fail++;
      $display("FAIL reset_cnt: got %h / %h expected 0", w_cnt, s_cnt); end
    n_checks++; if (w_ovf !== 8'h0 || s_ovf !== 8'h0) begin n_fail++;
      $display("FAIL reset_ovf: got %h / %h expected 0", w_ovf, s_ovf); end
    n_checks++; if (w_sum !== 11'h0 || w_busy !== 1'b0 || w_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_sum: got sum %h busy %b valid %b expected 0 0 0", w_sum, w_busy, w_valid); end
    reset = 1'b0; en = '0; up_down = '0;
  endtask

  task automatic test_wrap();
    logic [7:0] ec [3] = '{8'hFF, 8'h00, 8'h01};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    load_val = '0; load_val[7:0] = 8'hFE; load = 8'h01;
    tick();
    load = '0;
    n_checks++; if (w_cnt[7:0] !== 8'hFE || w_ovf[0] !== 1'b0) begin n_fail++;
      $display("FAIL wrap_load: got %h ovf %b expected fe 0", w_cnt[7:0], w_ovf[0]); end
    en = 8'h01; up_down = 8'h01;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++; if (w_cnt[7:0] !== ec[e] || w_ovf[0] !== eo[e]) begin n_fail++;
        $display("FAIL wrap_up%0d: got %h ovf %b expected %h %b", e, w_cnt[7:0], w_ovf[0], ec[e], eo[e]); end
    end
    n_checks++; if (s_cnt[7:0] !== 8'hFF || s_ovf[0] !== 1'b1) begin n_fail++;
      $display("FAIL sat_up_clamp: got %h ovf %b expected ff 1", s_cnt[7:0], s_ovf[0]); end
    en = '0;
    tick();
    n_checks++; if (w_cnt[7:0] !== 8'h01 || w_ovf[0] !== 1'b0) begin n_fail++;
      $display("FAIL wrap_hold: got %h ovf %b expected 01 0", w_cnt[7:0], w_ovf[0]); end
  endtask

  task automatic test_sat();
    logic [7:0] sc [3] = '{8'h00, 8'h00, 8'h00};
    logic       so [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] wc [3] = '{8'h00, 8'hFF, 8'hFE};
    logic       wo [3] = '{1'b0, 1'b1, 1'b0};
    load_val = '0; load_val[15:8] = 8'h01; load = 8'h02;
    tick();
    load = '0; en = 8'h02; up_down = 8'h00;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++; if (s_cnt[15:8] !== sc[e] || s_ovf[1] !== so[e]) begin n_fail++;
        $display("FAIL sat_down%0d: got %h ovf %b expected %h %b", e, s_cnt[15:8], s_ovf[1], sc[e], so[e]); end
      n_checks++; if (w_cnt[15:8] !== wc[e] || w_ovf[1] !== wo[e]) begin n_fail++;
        $display("FAIL wrap_down%0d: got %h ovf %b expected %h %b", e, w_cnt[15:8], w_ovf[1], wc[e], wo[e]); end
    end
    up_down = 8'h02;
    tick();
    n_checks++; if (s_cnt[15:8] !== 8'h01 || s_ovf[1] !== 1'b0) begin n_fail++;
      $display("FAIL sat_up_after: got %h ovf %b expected 01 0", s_cnt[15:8], s_ovf[1]); end
    en = '0; up_down = '0;
  endtask

  task automatic test_sum_max();
    int busy_cycles = 0;
    load_val = '1; load = '1;
    tick();
    load = '0;
    n_checks++; if (w_cnt !== {64{1'b1}}) begin n_fail++;
      $display("FAIL max_load: got %h expected all ff", w_cnt); end
    sum_req = 1'b1;
    tick();
    sum_req = 1'b0;
    if (w_busy) busy_cycles++;
    n_checks++; if (w_busy !== 1'b1 || w_valid !== 1'b0) begin n_fail++;
      $display("FAIL max_start: got busy %b valid %b expected 1 0", w_busy, w_valid); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (w_busy) busy_cycles++;
      if (e < 8) begin
        n_checks++; if (w_valid !== 1'b0) begin n_fail++;
          $display("FAIL max_early_valid%0d: got %b expected 0", e, w_valid); end
      end else begin
        n_checks++; if (w_valid !== 1'b1 || w_sum !== 11'h7F8 || s_sum !== 11'h7F8) begin n_fail++;
          $display("FAIL max_result: got valid %b sum %h / %h expected 1 7f8", w_valid, w_sum, s_sum); end
      end
    end
    tick();
    if (w_busy) busy_cycles++;
    n_checks++; if (w_valid !== 1'b0 || w_busy !== 1'b0 || w_sum !== 11'h7F8) begin n_fail++;
      $display("FAIL max_after: got valid %b busy %b sum %h expected 0 0 7f8", w_valid, w_busy, w_sum); end
    n_checks++; if (busy_cycles != 9) begin n_fail++;
      $display("FAIL max_busy_len: got %0d expected 9", busy_cycles); end
  endtask

  task automatic test_clear_during_sum();
    int edges;
    load_ramp();
    sum_req = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    n_checks++; if (w_cnt !== 64'h0) begin n_fail++;
      $display("FAIL clr_cnt: got %h expected 0", w_cnt); end
    load_val = {8{8'h02}}; load = '1;
    tick();
    load = '0;
    edges = 4;
    while (!w_valid && edges < 20) begin tick(); edges++; end
    n_checks++; if (edges != 8 || w_sum !== 11'd36 || s_sum !== 11'd36) begin n_fail++;
      $display("FAIL clr_result: got edges %0d sum %0d / %0d expected 8 36", edges, w_sum, s_sum); end
    tick();
    n_checks++; if (w_busy !== 1'b0 || w_valid !== 1'b0) begin n_fail++;
      $display("FAIL clr_done_ignore: got busy %b valid %b expected 0 0", w_busy, w_valid); end
    tick();
    sum_req = 1'b0;
    n_checks++; if (w_busy !== 1'b1) begin n_fail++;
      $display("FAIL clr_second_accept: got busy %b expected 1", w_busy); end
    edges = 0;
    while (!w_valid && edges < 20) begin tick(); edges++; end
    n_checks++; if (edges != 8 || w_sum !== 11'd16) begin n_fail++;
      $display("FAIL clr_second_sum: got edges %0d sum %0d expected 8 16", edges, w_sum); end
    tick();
  endtask

  task automatic test_reset_mid_sum();
    int edges;
    bit seen = 1'b0;
    load_ramp();
    sum_req = 1'b1;
    tick();
    sum_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (w_busy !== 1'b0 || w_valid !== 1'b0 || w_sum !== 11'h0 || w_cnt !== 64'h0) begin n_fail++;
      $display("FAIL rst_mid_state: got busy %b valid %b sum %h cnt %h expected 0 0 0 0", w_busy, w_valid, w_sum, w_cnt); end
    for (int e = 0; e < 12; e++) begin
      tick();
      if (w_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_no_valid: got valid seen %b expected 0", seen); end
    load_val = {8{8'h03}}; load = '1;
    tick();
    load = '0; sum_req = 1'b1;
    tick();
    sum_req = 1'b0;
    edges = 0;
    while (!w_valid && edges < 20) begin tick(); edges++; end
    n_checks++; if (edges != 8 || w_sum !== 11'd24) begin n_fail++;
      $display("FAIL rst_mid_resum: got edges %0d sum %0d expected 8 24", edges, w_sum); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sat();
    test_sum_max();
    test_clear_during_sum();
    test_reset_mid_sum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
